// File: rtl/ad_ip_jesd204_tpl_dac_fifo_pkg.sv
// Shared definitions for the TPL DAC sample FIFO: FSM encoding and status widths.
package ad_ip_jesd204_tpl_dac_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } fsm_state_t;

  localparam int UNF_CNT_WIDTH = 16;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
// Simple dual-port register array: clocked write port, asynchronous read of the head.
module ad_mem_sync_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [0:(1<<ADDR_WIDTH)-1];

  // Storage write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// DMA-to-TPL sample FIFO with prefill gating, show-ahead output and underflow reporting.
module ad_ip_jesd204_tpl_dac_fifo
  import ad_ip_jesd204_tpl_dac_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_CHANNELS = 2,
  parameter int DEPTH_LOG2   = 4,
  parameter int PREFILL      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_axis_valid,
  output logic                     s_axis_ready,
  input  logic [DATA_WIDTH-1:0]    s_axis_data,
  input  logic [NUM_CHANNELS-1:0]  enable,
  input  logic [NUM_CHANNELS-1:0]  dac_valid,
  output logic [DATA_WIDTH-1:0]    dac_ddata,
  output logic                     dac_dunf,
  output logic [DEPTH_LOG2:0]      status_level,
  output logic [UNF_CNT_WIDTH-1:0] status_unf_count
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]         DEPTH_L   = LW'(2**DEPTH_LOG2);
  localparam logic [LW-1:0]         PREFILL_L = LW'(PREFILL);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1'b1);
  localparam logic [UNF_CNT_WIDTH-1:0] UNF_MAX = {UNF_CNT_WIDTH{1'b1}};

  fsm_state_t                state_r;
  fsm_state_t                state_nxt_s;
  logic [DEPTH_LOG2-1:0]     wr_ptr_r;
  logic [DEPTH_LOG2-1:0]     rd_ptr_r;
  logic [LW-1:0]             level_r;
  logic [LW-1:0]             level_nxt_s;
  logic                      ready_s;
  logic                      wr_en_s;
  logic                      rd_req_s;
  logic                      pop_s;
  logic                      unf_s;
  logic                      flush_s;
  logic [DATA_WIDTH-1:0]     head_s;
  logic [DATA_WIDTH-1:0]     ddata_s;
  logic                      dunf_r;
  logic [UNF_CNT_WIDTH-1:0]  unf_cnt_r;

  ad_mem_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) i_mem (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (s_axis_data),
    .rd_addr (rd_ptr_r),
    .rd_data (head_s)
  );

  // Handshake, pop/underflow decisions, occupancy update and next FSM state.
  always_comb begin
    ready_s     = (level_r < DEPTH_L) && (state_r != IDLE) && !reset;
    wr_en_s     = s_axis_valid && ready_s;
    rd_req_s    = |(dac_valid & enable);
    pop_s       = (state_r == RUN) && rd_req_s && (level_r != {LW{1'b0}});
    unf_s       = (state_r == RUN) && rd_req_s && (level_r == {LW{1'b0}});
    level_nxt_s = level_r + LW'(wr_en_s) - LW'(pop_s);
    ddata_s     = {DATA_WIDTH{1'b0}};
    state_nxt_s = state_r;
    flush_s     = 1'b0;
    if ((state_r == RUN) && (level_r != {LW{1'b0}})) begin
      ddata_s = head_s;
    end else begin
      ddata_s = {DATA_WIDTH{1'b0}};
    end
    if (enable == {NUM_CHANNELS{1'b0}}) begin
      state_nxt_s = IDLE;
      flush_s     = 1'b1;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = FILL;
        // Compare against the post-edge level so RUN starts the cycle prefill completes.
        FILL: begin
          if (level_nxt_s >= PREFILL_L) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = FILL;
          end
        end
        RUN:     state_nxt_s = RUN;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pointers, occupancy, underflow pulse and saturating underflow counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r  <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r  <= {DEPTH_LOG2{1'b0}};
      level_r   <= {LW{1'b0}};
      dunf_r    <= 1'b0;
      unf_cnt_r <= {UNF_CNT_WIDTH{1'b0}};
    end else begin
      if (flush_s) begin
        wr_ptr_r <= {DEPTH_LOG2{1'b0}};
        rd_ptr_r <= {DEPTH_LOG2{1'b0}};
        level_r  <= {LW{1'b0}};
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
        level_r <= level_nxt_s;
      end
      dunf_r <= unf_s;
      if (dunf_r && (unf_cnt_r != UNF_MAX)) begin
        unf_cnt_r <= unf_cnt_r + {{(UNF_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign s_axis_ready     = ready_s;
  assign dac_ddata        = ddata_s;
  assign dac_dunf         = dunf_r;
  assign status_level     = level_r;
  assign status_unf_count = unf_cnt_r;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv
// Self-checking bench: randomized traffic against a queue-based reference of the FIFO rules.
module tb_ad_ip_jesd204_tpl_dac_fifo;

  logic         clk;
  logic         reset;
  logic         s_axis_valid;
  logic         s_axis_ready;
  logic [127:0] s_axis_data;
  logic [1:0]   enable;
  logic [1:0]   dac_valid;
  logic [127:0] dac_ddata;
  logic         dac_dunf;
  logic [4:0]   status_level;
  logic [15:0]  status_unf_count;

  int     checks;
  int     errors;
  bit     do_check;
  string  cur_test;

  // reference model: mode 0=idle 1=fill 2=run, queue of stored words
  int           m_mode;
  logic [127:0] m_q[$];
  logic         m_dunf;
  int           m_cnt;

  ad_ip_jesd204_tpl_dac_fifo dut (
    .clk              (clk),
    .reset            (reset),
    .s_axis_valid     (s_axis_valid),
    .s_axis_ready     (s_axis_ready),
    .s_axis_data      (s_axis_data),
    .enable           (enable),
    .dac_valid        (dac_valid),
    .dac_ddata        (dac_ddata),
    .dac_dunf         (dac_dunf),
    .status_level     (status_level),
    .status_unf_count (status_unf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] wd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, compare against model, advance the model.
  task automatic cycle(input logic r, input logic [1:0] en, input logic v,
                       input logic [127:0] d, input logic [1:0] dv);
    logic [127:0] e_data;
    logic         e_ready;
    logic [4:0]   e_lvl;
    logic [15:0]  e_cnt;
    logic         rd;
    logic         acc;
    logic         new_dunf;
    reset = r; enable = en; s_axis_valid = v; s_axis_data = d; dac_valid = dv;
    #1;
    e_ready = !r && (m_mode != 0) && (m_q.size() < 16);
    e_data  = (m_mode == 2 && m_q.size() > 0) ? m_q[0] : 128'd0;
    e_lvl   = 5'(m_q.size());
    e_cnt   = 16'(m_cnt);
    if (do_check) begin
      checks++;
      if (s_axis_ready !== e_ready) begin
        errors++; $display("FAIL %s ready: got %b expected %b", cur_test, s_axis_ready, e_ready);
      end
      checks++;
      if (dac_ddata !== e_data) begin
        errors++; $display("FAIL %s ddata: got %h expected %h", cur_test, dac_ddata, e_data);
      end
      checks++;
      if (dac_dunf !== m_dunf) begin
        errors++; $display("FAIL %s dunf: got %b expected %b", cur_test, dac_dunf, m_dunf);
      end
      checks++;
      if (status_level !== e_lvl) begin
        errors++; $display("FAIL %s level: got %0d expected %0d", cur_test, status_level, e_lvl);
      end
      checks++;
      if (status_unf_count !== e_cnt) begin
        errors++; $display("FAIL %s unf_count: got %0d expected %0d", cur_test, status_unf_count, e_cnt);
      end
    end
    acc = v && e_ready;
    rd  = |(dv & en);
    if (r) begin
      m_mode = 0; m_q.delete(); m_dunf = 1'b0; m_cnt = 0;
    end else begin
      new_dunf = (m_mode == 2) && rd && (m_q.size() == 0);
      if (m_dunf && m_cnt < 65535) m_cnt++;
      if (en == 2'b00) begin
        m_mode = 0; m_q.delete();
      end else begin
        if (m_mode == 2 && rd && m_q.size() > 0) void'(m_q.pop_front());
        if (acc) m_q.push_back(d);
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && m_q.size() >= 8) m_mode = 2;
      end
      m_dunf = new_dunf;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset, enable, write words 1..8 (reaches RUN), then read down to n words.
  task automatic fill_run(input int n);
    cycle(1'b1, 2'b11, 1'b0, 128'd0, 2'b00);
    cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b00);
    for (int k = 0; k < 8; k++) cycle(1'b0, 2'b11, 1'b1, 128'(k + 1), 2'b00);
    for (int k = 0; k < 8 - n; k++) cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b01);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    do_check = 1'b0;
    cycle(1'b1, 2'b11, 1'b1, wd(), 2'b11);
    do_check = 1'b1;
    cycle(1'b1, 2'b11, 1'b1, wd(), 2'b11);
    checks++;
    if (status_level !== 5'd0 || s_axis_ready !== 1'b0 || dac_ddata !== 128'd0 ||
        dac_dunf !== 1'b0 || status_unf_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got lvl=%0d rdy=%b dd=%h unf=%b cnt=%0d expected all zero",
               status_level, s_axis_ready, dac_ddata, dac_dunf, status_unf_count);
    end
  endtask

  task automatic test_prefill();
    cur_test = "prefill";
    cycle(1'b1, 2'b11, 1'b0, 128'd0, 2'b00);
    cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dac_ddata !== 128'd0) begin
        errors++; $display("FAIL prefill_zero: got %h expected 0", dac_ddata);
      end
      cycle(1'b0, 2'b11, 1'b1, 128'(i + 1), 2'b11);
    end
    checks++;
    if (dac_ddata !== 128'd1 || status_level !== 5'd8) begin
      errors++; $display("FAIL prefill_entry: got dd=%h lvl=%0d expected dd=1 lvl=8", dac_ddata, status_level);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dac_ddata !== 128'(i + 1)) begin
        errors++; $display("FAIL prefill_order: got %h expected %h", dac_ddata, 128'(i + 1));
      end
      cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b10);
    end
  endtask

  task automatic test_underflow();
    cur_test = "underflow";
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dac_dunf !== ((i >= 1) && (i <= 3)) || dac_ddata !== 128'd0) begin
        errors++; $display("FAIL underflow_pulse: got dunf=%b dd=%h expected dunf=%b dd=0",
                           dac_dunf, dac_ddata, ((i >= 1) && (i <= 3)));
      end
      cycle(1'b0, 2'b11, 1'b0, 128'd0, (i < 3) ? 2'b11 : 2'b00);
    end
    checks++;
    if (status_unf_count !== 16'd3) begin
      errors++; $display("FAIL underflow_count: got %0d expected 3", status_unf_count);
    end
  endtask

  task automatic test_full_wrap();
    cur_test = "full_wrap";
    cycle(1'b1, 2'b11, 1'b0, 128'd0, 2'b00);
    cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b00);
    for (int i = 0; i < 16; i++) cycle(1'b0, 2'b11, 1'b1, wd(), 2'b00);
    checks++;
    if (s_axis_ready !== 1'b0 || status_level !== 5'd16) begin
      errors++; $display("FAIL full_ready: got rdy=%b lvl=%0d expected rdy=0 lvl=16", s_axis_ready, status_level);
    end
    cycle(1'b0, 2'b11, 1'b1, wd(), 2'b00);
    checks++;
    if (status_level !== 5'd16) begin
      errors++; $display("FAIL full_17th: got lvl=%0d expected 16", status_level);
    end
    for (int i = 0; i < 40; i++)
      cycle(1'b0, 2'b11, 1'($urandom_range(0, 3) != 0), wd(), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_simultaneous();
    logic [127:0] w[$];
    logic [127:0] d;
    cur_test = "simultaneous";
    fill_run(5);
    for (int k = 1; k <= 8; k++) w.push_back(128'(k));
    for (int i = 0; i < 10; i++) begin
      d = wd();
      w.push_back(d);
      checks++;
      if (status_level !== 5'd5 || dac_ddata !== w[3 + i]) begin
        errors++; $display("FAIL simultaneous: got lvl=%0d dd=%h expected lvl=5 dd=%h",
                           status_level, dac_ddata, w[3 + i]);
      end
      cycle(1'b0, 2'b11, 1'b1, d, 2'b11);
    end
  endtask

  task automatic test_disable();
    cur_test = "disable";
    fill_run(6);
    cycle(1'b0, 2'b00, 1'b1, wd(), 2'b00);
    checks++;
    if (status_level !== 5'd0 || dac_ddata !== 128'd0 || s_axis_ready !== 1'b0) begin
      errors++; $display("FAIL disable_flush: got lvl=%0d dd=%h rdy=%b expected 0 0 0",
                         status_level, dac_ddata, s_axis_ready);
    end
    cur_test = "reset_mid";
    fill_run(6);
    cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b11);
    cycle(1'b1, 2'b11, 1'b1, wd(), 2'b11);
    checks++;
    if (status_level !== 5'd0 || dac_ddata !== 128'd0 || s_axis_ready !== 1'b0 ||
        status_unf_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid: got lvl=%0d dd=%h rdy=%b cnt=%0d expected all zero",
                         status_level, dac_ddata, s_axis_ready, status_unf_count);
    end
  endtask

  task automatic test_random();
    logic [1:0] en;
    cur_test = "random";
    cycle(1'b1, 2'b11, 1'b0, 128'd0, 2'b00);
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 40) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      cycle(1'($urandom_range(0, 150) == 0), en, 1'($urandom_range(0, 2) != 0),
            wd(), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_saturation();
    cur_test = "saturation";
    fill_run(0);
    do_check = 1'b0;
    for (int i = 0; i < 65540; i++) cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b11);
    do_check = 1'b1;
    cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b00);
    cycle(1'b0, 2'b11, 1'b0, 128'd0, 2'b00);
    checks++;
    if (status_unf_count !== 16'hFFFF) begin
      errors++; $display("FAIL saturation: got %h expected ffff", status_unf_count);
    end
  endtask

  initial begin
    checks = 0; errors = 0; do_check = 1'b0;
    m_mode = 0; m_dunf = 1'b0; m_cnt = 0;
    reset = 1'b1; enable = 2'b00; s_axis_valid = 1'b0; s_axis_data = 128'd0; dac_valid = 2'b00;
    test_reset();
    test_prefill();
    test_underflow();
    test_full_wrap();
    test_simultaneous();
    test_disable();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_fifo.md
AD_IP_JESD204_TPL_DAC_FIFO -- requirements
Module: ad_ip_jesd204_tpl_dac_fifo

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 128, DMA-side sample word width.
- NUM_CHANNELS, 2, number of converter channels.
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 words.
- PREFILL, 8, occupancy required before output starts (1..2**DEPTH_LOG2).

REQ-002 Ports SHALL be (one clock; reset is synchronous and active-high):
- clk, in, 1, link clock, sole clock.
- reset, in, 1, synchronous active-high reset.
- s_axis_valid, in, 1, DMA word valid.
- s_axis_ready, out, 1, FIFO can accept a word.
- s_axis_data, in, DATA_WIDTH, DMA word.
- enable, in, NUM_CHANNELS, channel enables from TPL.
- dac_valid, in, NUM_CHANNELS, per-channel read strobes from TPL.
- dac_ddata, out, DATA_WIDTH, sample word to TPL.
- dac_dunf, out, 1, underflow pulse to TPL.
- status_level, out, DEPTH_LOG2+1, current occupancy.
- status_unf_count, out, 16, saturating underflow count.

Function
REQ-003 Write SHALL occur on a cycle where s_axis_valid && s_axis_ready; s_axis_ready SHALL be high iff level < 2**DEPTH_LOG2, state != IDLE, and reset is low.
REQ-004 rd_req SHALL be |(dac_valid & enable).
REQ-005 FSM states SHALL be IDLE, FILL, RUN.
- IDLE -> FILL when enable != 0.
- FILL -> RUN when level >= PREFILL.
- Any state -> IDLE when enable == 0, and this SHALL flush the FIFO (level = 0, pointers = 0) on the next edge.
REQ-006 In IDLE and FILL, dac_ddata SHALL be all-zero, and rd_req SHALL NOT pop or flag underflow.
REQ-007 In RUN, dac_ddata SHALL show the head word (show-ahead, zero latency from the pop decision). rd_req with level > 0 SHALL pop exactly one word.
REQ-008 In RUN with level == 0, dac_ddata SHALL be all-zero. rd_req in that condition SHALL raise dac_dunf for exactly the next cycle (registered, one cycle latency), and the state SHALL remain RUN.
REQ-009 A simultaneous write and pop SHALL leave level unchanged.
REQ-010 A write into an empty FIFO concurrent with rd_req SHALL NOT satisfy that read; underflow is flagged, and the written word becomes head on the next cycle.
REQ-011 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth. Level SHALL be DEPTH_LOG2+1 bits and range 0..2**DEPTH_LOG2.
REQ-012 status_unf_count SHALL increment on each dac_dunf pulse and saturate at 0xFFFF. It is cleared only by reset.
REQ-013 Words SHALL be output in write order, bit-exact, with no reordering.

Reset
REQ-014 While reset is high, at the next clk edge:
- state = IDLE, pointers = 0, level = 0.
- s_axis_ready = 0, dac_ddata = 0, dac_dunf = 0, status_unf_count = 0.
REQ-015 Reset asserted mid-stream SHALL discard all stored words. After release, operation SHALL resume from IDLE per REQ-005.
REQ-016 Storage array contents SHALL NOT require reset.

Structure
REQ-017 A shared package SHALL hold:
- the FSM state encoding: IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2;
- the underflow counter width constant (16).
REQ-018 Storage SHALL be one sub-module, ad_mem_sync_fifo: a simple dual-port register array, write port plus asynchronous read of the head address. The FSM, pointers and status SHALL sit in the top module.

Verification
REQ-019 Prefill: enable = 2'b11, write 8 words 0x1..0x8.
- State reaches RUN on the cycle level hits 8.
- dac_ddata = 0 before that cycle, 0x1 at RUN entry.
- 8 reads return 0x1..0x8 in order.
REQ-020 Underflow: in RUN with level = 0, assert dac_valid for 3 cycles.
- dac_ddata = 0 throughout.
- dac_dunf high for 3 cycles, each delayed one cycle from its read.
- status_unf_count = 3.
REQ-021 Full/wrap: DEPTH_LOG2 = 4, dac_valid = 0, write 16 words.
- s_axis_ready drops with level = 16, and the 17th word is not accepted.
- Then 40 interleaved write/read cycles: no loss, pointers wrap, output order correct.
REQ-022 Simultaneous: level = 5, write and read together for 10 cycles.
- level stays 5.
- Output sequence equals input sequence delayed by 5 words.
REQ-023 Disable/reset mid-stream: level = 6 in RUN.
- Drive enable = 0: next cycle state = IDLE, level = 0, dac_ddata = 0.
- Repeat with reset = 1 instead: same result, and status_unf_count = 0.
REQ-024 Saturation: force 65,540 underflow reads; status_unf_count holds at 0xFFFF.
